load_store_unit: RTL

// - Memory stage directly downstream of the ALU: takes the ALU effective address plus rs2 store data.
// - Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW against a word-wide data-memory port with a req/ready handshake.
// - Returns the sign/zero-extended load result to writeback. Flags misaligned and timed-out accesses.

---
 rtl/load_store_unit_pkg.sv | 19 +
 rtl/lsu_align.sv | 90 +++++++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Contents:
//   LSU_B/H/W/BU/HU : funct3 access-width codes
//   lsu_state_e     : FSM state encoding (IDLE, REQ, RESP)
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Computes the byte enables, the replicated store data, the extracted and
// extended load data, and the legality check for one access description.
// Ports:
//   is_load   in  1   1 = load, 0 = store
//   funct3    in  3   access width code
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  raw store data (rs2)
//   rdata     in  32  raw memory read word
//   be        out 4   byte enables
//   wdata_rep out 32  store data replicated into every lane
//   rdata_ext out 32  extracted, sign/zero-extended load data
//   illegal   out 1   misaligned address or unsupported funct3
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and half-word out of the read word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Per-width enables, lane replication, extension and legality.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    rdata_ext = 32'h0000_0000;
    illegal   = 1'b0;
    case (funct3)
      LSU_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_s[7]}}, byte_s};
      end
      LSU_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h00_0000, byte_s};
        illegal   = ~is_load;  // unsigned variants exist only for loads
      end
      LSU_H: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_s[15]}}, half_s};
        illegal   = addr_lo[0];
      end
      LSU_HU: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0000, half_s};
        illegal   = addr_lo[0] | ~is_load;
      end
      LSU_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        illegal   = (addr_lo != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: executes LB/LH/LW/LBU/LHU/SB/SH/SW over a word-wide
// req/ready data-memory port, returns the extended load result and flags
// misaligned/illegal and timed-out accesses.
// Ports:
//   clk, reset (async, active-high)
//   valid_in, is_load, funct3, addr_in, wdata_in : request, sampled in IDLE
//   busy, done, load_data, err_misalign, err_timeout : pipeline side
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_ready, mem_rdata : memory side
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  lsu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             is_load_r;
  logic [2:0]       funct3_r;
  logic [1:0]       addr_lo_r;

  logic             sel_is_load_s;
  logic [2:0]       sel_funct3_s;
  logic [1:0]       sel_addr_lo_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_rep_s;
  logic [31:0]      rdata_ext_s;
  logic             illegal_s;

  assign cnt_next_s = cnt_r + CNT_W'(1);

  // One aligner serves both directions: live request in IDLE, latched one afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      sel_is_load_s = is_load;
      sel_funct3_s  = funct3;
      sel_addr_lo_s = addr_in[1:0];
    end else begin
      sel_is_load_s = is_load_r;
      sel_funct3_s  = funct3_r;
      sel_addr_lo_s = addr_lo_r;
    end
  end

  lsu_align u_align (
    .is_load   (sel_is_load_s),
    .funct3    (sel_funct3_s),
    .addr_lo   (sel_addr_lo_s),
    .wdata     (wdata_in),
    .rdata     (mem_rdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .rdata_ext (rdata_ext_s),
    .illegal   (illegal_s)
  );

  // Access FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      is_load_r    <= 1'b0;
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_data    <= 32'h0000_0000;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0000_0000;
      mem_be       <= 4'b0000;
      mem_wdata    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done         <= 1'b0;
          err_misalign <= 1'b0;
          err_timeout  <= 1'b0;
          cnt_r        <= '0;
          if (valid_in) begin
            busy      <= 1'b1;
            is_load_r <= is_load;
            funct3_r  <= funct3;
            addr_lo_r <= addr_in[1:0];
            if (illegal_s) begin
              // Rejected without touching memory: report straight away.
              state_r      <= ST_RESP;
              done         <= 1'b1;
              err_misalign <= 1'b1;
            end else begin
              state_r   <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= ~is_load;
              mem_addr  <= {addr_in[31:2], 2'b00};
              mem_be    <= be_s;
              mem_wdata <= wdata_rep_s;
            end
          end
        end
        ST_REQ: begin
          cnt_r <= cnt_next_s;
          if (mem_ready) begin
            // Ready wins over a timeout landing in the same cycle.
            state_r <= ST_RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (is_load_r) begin
              load_data <= rdata_ext_s;
            end
          end else if ((TIMEOUT_CYC != 0) && (cnt_next_s == TO_VAL)) begin
            state_r     <= ST_RESP;
            mem_req     <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          err_misalign <= 1'b0;
          err_timeout  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
